// File: rtl/hazard_forwarding_unit.sv
// Load-use / branch hazard controller and EX operand-forwarding selects for the five-stage core.
// Optional macro HAZARD_FWD_EN: forwarding enabled, stall only on load-use (else stall on any RAW match).
module hazard_forwarding_unit #(
    parameter int REG_BITS   = 4,
    parameter int LOAD_STALL = 1
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [REG_BITS-1:0] ID_Rn,
    input  logic [REG_BITS-1:0] ID_Rm,
    input  logic                ID_use_rn,
    input  logic                ID_use_rm,
    input  logic [REG_BITS-1:0] ID_Rd,
    input  logic                ID_rf,
    input  logic                ID_load,
    input  logic                branch_taken,
    output logic                PC_LE,
    output logic                IFID_LE,
    output logic                IFID_CLR,
    output logic                IDEX_CLR,
    output logic [1:0]          FWD_A,
    output logic [1:0]          FWD_B,
    output logic                stall_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] HOLD_INIT = 2'(LOAD_STALL - 1);

    state_t              state_r;
    logic [1:0]          cnt_r;

    logic [REG_BITS-1:0] ex_rd_r;
    logic                ex_rf_r;
    logic                ex_ld_r;
    logic [REG_BITS-1:0] mem_rd_r;
    logic                mem_rf_r;
    logic [REG_BITS-1:0] wb_rd_r;
    logic                wb_rf_r;

    logic                ex_a_s;
    logic                mem_a_s;
    logic                wb_a_s;
    logic                ex_b_s;
    logic                mem_b_s;
    logic                wb_b_s;
    logic                load_use_s;
    logic                stall_s;
    logic [1:0]          fwd_a_s;
    logic [1:0]          fwd_b_s;

    function automatic logic slot_match(
        input logic                used,
        input logic                rf,
        input logic [REG_BITS-1:0] rd,
        input logic [REG_BITS-1:0] src
    );
        return used & rf & (rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        if (ex_hit) begin
            sel = 2'b01;
        end else if (mem_hit) begin
            sel = 2'b10;
        end else if (wb_hit) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Per-operand source matches against every tracker slot
    always_comb begin
        ex_a_s  = slot_match(ID_use_rn, ex_rf_r,  ex_rd_r,  ID_Rn);
        mem_a_s = slot_match(ID_use_rn, mem_rf_r, mem_rd_r, ID_Rn);
        wb_a_s  = slot_match(ID_use_rn, wb_rf_r,  wb_rd_r,  ID_Rn);
        ex_b_s  = slot_match(ID_use_rm, ex_rf_r,  ex_rd_r,  ID_Rm);
        mem_b_s = slot_match(ID_use_rm, mem_rf_r, mem_rd_r, ID_Rm);
        wb_b_s  = slot_match(ID_use_rm, wb_rf_r,  wb_rd_r,  ID_Rm);
    end

    // Stall decision and forwarding selects
    always_comb begin
        load_use_s = 1'b0;
        stall_s    = 1'b0;
        fwd_a_s    = 2'b00;
        fwd_b_s    = 2'b00;
`ifdef HAZARD_FWD_EN
        load_use_s = ex_ld_r & (ex_a_s | ex_b_s);
        stall_s    = (state_r == ST_HOLD) | load_use_s;
        // A load still in EX cannot forward; fall through to the older slots
        fwd_a_s    = fwd_sel(ex_a_s & ~ex_ld_r, mem_a_s, wb_a_s);
        fwd_b_s    = fwd_sel(ex_b_s & ~ex_ld_r, mem_b_s, wb_b_s);
`else
        stall_s    = ex_a_s | mem_a_s | wb_a_s | ex_b_s | mem_b_s | wb_b_s;
`endif
    end

    // Pipeline control outputs
    always_comb begin
        PC_LE    = ~stall_s;
        IFID_LE  = ~stall_s;
        IDEX_CLR = stall_s;
        stall_o  = stall_s;
        IFID_CLR = branch_taken & ~stall_s;
        FWD_A    = fwd_a_s;
        FWD_B    = fwd_b_s;
    end

    // Destination tracker: EX -> MEM -> WB, bubble injected into EX on stall
    always_ff @(posedge CLK) begin
        if (CLR) begin
            ex_rd_r  <= '0;
            ex_rf_r  <= 1'b0;
            ex_ld_r  <= 1'b0;
            mem_rd_r <= '0;
            mem_rf_r <= 1'b0;
            wb_rd_r  <= '0;
            wb_rf_r  <= 1'b0;
        end else begin
            mem_rd_r <= ex_rd_r;
            mem_rf_r <= ex_rf_r;
            wb_rd_r  <= mem_rd_r;
            wb_rf_r  <= mem_rf_r;
            if (stall_s) begin
                ex_rd_r <= '0;
                ex_rf_r <= 1'b0;
                ex_ld_r <= 1'b0;
            end else begin
                ex_rd_r <= ID_Rd;
                ex_rf_r <= ID_rf;
                ex_ld_r <= ID_load;
            end
        end
    end

    // Load-use stall extension FSM
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
        end else begin
`ifdef HAZARD_FWD_EN
            case (state_r)
                ST_RUN: begin
                    if (load_use_s && (LOAD_STALL > 1)) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= HOLD_INIT;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= 2'd0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r <= 2'd1) begin
                        state_r <= ST_RUN;
                        cnt_r   <= 2'd0;
                    end else begin
                        state_r <= ST_HOLD;
                        cnt_r   <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= 2'd0;
                end
            endcase
`else
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
`endif
        end
    end

`ifndef HAZARD_FWD_EN
    // Load status and the hold counter only matter when forwarding is built in
    logic unused_ok_s;
    assign unused_ok_s = ^{ex_ld_r, load_use_s, state_r, cnt_r, HOLD_INIT};
`endif

endmodule
